q_episode_ctrl: RTL and testbench
=================================

Name: q_episode_ctrl

Overview:
Sequences Q-learning episodes for the 6x6 (36-state, 4-action) maze agent. Each step it:
- scans the Q table for the current state;
- selects an action epsilon-greedily using an LFSR;
- applies maze movement and wall rules to get the next state and reward;
- scans the next state for max Q;
- hands one update request to the Q-update datapath.

It sits between the Q-table RAM read port and the Q-update unit, and owns the episode and step counters.

Parameters:
- N_EPISODES, 100, episodes run per start
- MAX_STEPS, 64, step limit per episode; reaching it ends the episode
- START_STATE, 0, agent state at each episode start
- GOAL_STATE, 35, terminal state
- EPS_THRESH, 26, exploration threshold (8-bit; explore when lfsr[7:0] < EPS_THRESH)
- REWARD_GOAL, 10, integer reward for entering GOAL_STATE
- REWARD_WALL, -1, integer reward for bumping a wall or the grid edge (two's complement)
- LFSR_SEED, 16'hACE1, LFSR reset value; must be nonzero

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- start  in  1  begin a run; sampled in IDLE/DONE only
- wall_map  in  36  bit s=1 marks state s as blocked
- busy  out  1  high from the cycle after start until DONE
- done  out  1  high in DONE until the next start
- episode_cnt  out  16  completed episodes
- step_cnt  out  8  steps taken in the current episode
- cur_state  out  6  agent state
- q_rd_state  out  6  Q-table read state address
- q_rd_act  out  2  Q-table read action address
- q_rd_data  in  32  signed Q value; valid 1 cycle after address
- upd_valid  out  1  update request valid
- upd_ready  in  1  Q-update unit accepts request
- upd_state  out  6  state being updated
- upd_action  out  2  action taken
- upd_max_q  out  32  signed max Q over the next state's 4 actions
- upd_reward  out  32  signed integer reward (the datapath shifts it by 16)

Behaviour:
- Reset:
  - State IDLE; busy=0, done=0, upd_valid=0.
  - All counters 0; cur_state=START_STATE.
  - q_rd_* = 0; upd_* data = 0; lfsr=LFSR_SEED.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11; advances every cycle regardless of state.
- Actions and moves:
  - Encoding: 0 up (s-6), 1 right (s+1), 2 down (s+6), 3 left (s-1).
  - Off-grid checks: row 0 up, row 5 down, col 0 left, col 5 right.
  - An off-grid move, or a move into a wall_map-blocked cell, leaves next=cur with reward REWARD_WALL.
  - A move into GOAL_STATE gives REWARD_GOAL. Any other move gives 0.
- FSM:
  - IDLE: on start -> EP_INIT.
  - EP_INIT: cur_state=START_STATE, step_cnt=0 -> SCAN_CUR.
  - SCAN_CUR: issues reads a=0..3 on consecutive cycles. Keeps a running signed max and argmax over the 4 values. Ties resolve to the lower action index. Takes 5 cycles (4 issue + 1 latency) -> CHOOSE.
  - CHOOSE: if lfsr[7:0] < EPS_THRESH, action = lfsr[9:8]; otherwise action = argmax. -> MOVE.
  - MOVE: computes next_state and reward, registered in 1 cycle -> SCAN_NEXT.
  - SCAN_NEXT: same 5-cycle signed max scan on next_state -> ISSUE.
  - ISSUE: upd_valid=1 with upd_state=cur_state, upd_action, upd_max_q, upd_reward. All fields hold stable until the cycle upd_ready=1. That handshake cycle -> ADVANCE; upd_valid drops the next cycle.
  - ADVANCE: cur_state=next_state, step_cnt+1.
    - If next_state==GOAL_STATE or step_cnt+1==MAX_STEPS: episode_cnt+1 -> EP_END.
    - Otherwise -> SCAN_CUR.
  - EP_END: if episode_cnt==N_EPISODES -> DONE, else -> EP_INIT.
  - DONE: done=1, busy=0. On start: clear episode_cnt, done=0 -> EP_INIT.
- Start rules: start is ignored while busy. A start in the same cycle as rst is lost.
- Goal update: the goal-reaching update is still issued (with next-state max Q) before the episode terminates.
- Reset mid-operation: immediate return to IDLE. Any pending request is dropped with no upd_valid glitch. Counters are cleared.
- Latency per step, with upd_ready held high: 5+1+1+5+1+1 = 14 cycles.

Optional Feature:
EPS_DECAY_EN:
- Defined: an 8-bit eps register loads EPS_THRESH on start. At each EP_END it decrements by 1, saturating at 0. CHOOSE compares against eps.
- Undefined: EPS_THRESH is used as a constant and no eps register exists.

Test Plan:
- All-zero Q table, EPS_THRESH=0, no walls, start:
  - Greedy always picks action 0 from state 0, so every step is an edge bump.
  - Each request has state 0, action 0, reward -1 (32'hFFFFFFFF), max_q 0.
  - The episode ends at step_cnt=64; episode_cnt increments to 1.
- Q stub with action 1 = 5<<16 on row 0 and action 2 = 5<<16 on col 5, others 0, EPS_THRESH=0:
  - Path 0->1->…->5->11->…->35 reaches the goal in 10 steps.
  - The 10th request has reward 10; episode_cnt increments at step 10.
- Next-state Q values {-5,3,7,-2}<<16 -> upd_max_q=7<<16. With all four equal to -3<<16 -> max = -3<<16 and argmax = 0.
- Hold upd_ready=0 for 5 cycles in ISSUE -> upd_valid stays 1 and all upd_* fields are unchanged. Exactly one handshake occurs and step_cnt increments once.
- Assert rst 2 cycles into ISSUE -> next cycle shows upd_valid=0, IDLE, counters 0. A later start gives a clean episode from state 0.
- wall_map bit 1 set, greedy action 1 at state 0 -> next_state 0, reward -1. N_EPISODES=2 -> done rises after the 2nd EP_END, and start is ignored while busy.

Source files
------------

// File: rtl/q_episode_ctrl_if.sv
// Q-table read port and Q-update request bundle for the episode controller.
interface q_episode_ctrl_if;
  logic        [5:0]  q_rd_state;
  logic        [1:0]  q_rd_act;
  logic signed [31:0] q_rd_data;
  logic               upd_valid;
  logic               upd_ready;
  logic        [5:0]  upd_state;
  logic        [1:0]  upd_action;
  logic signed [31:0] upd_max_q;
  logic signed [31:0] upd_reward;

  modport master (
    output q_rd_state, q_rd_act,
    input  q_rd_data,
    output upd_valid,
    input  upd_ready,
    output upd_state, upd_action, upd_max_q, upd_reward
  );

  modport slave (
    input  q_rd_state, q_rd_act,
    output q_rd_data,
    input  upd_valid,
    output upd_ready,
    input  upd_state, upd_action, upd_max_q, upd_reward
  );
endinterface

// File: rtl/q_episode_ctrl.sv
// Q-learning episode sequencer for a 6x6 maze: scan, epsilon-greedy choose, move, scan next, issue update.
// Optional EPS_DECAY_EN: per-run epsilon register that decays by one per episode.
module q_episode_ctrl #(
  parameter int          N_EPISODES  = 100,
  parameter int          MAX_STEPS   = 64,
  parameter int          START_STATE = 0,
  parameter int          GOAL_STATE  = 35,
  parameter logic [7:0]  EPS_THRESH  = 8'd26,
  parameter int          REWARD_GOAL = 10,
  parameter int          REWARD_WALL = -1,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [35:0]      wall_map,
  output logic             busy,
  output logic             done,
  output logic [15:0]      episode_cnt,
  output logic [7:0]       step_cnt,
  output logic [5:0]       cur_state,
  q_episode_ctrl_if.master bus
);

  typedef enum logic [3:0] {
    S_IDLE, S_EP_INIT, S_SCAN_CUR, S_CHOOSE, S_MOVE,
    S_SCAN_NEXT, S_ISSUE, S_ADVANCE, S_EP_END, S_DONE
  } state_t;

  state_t state, nxt;

  logic [15:0]        lfsr;
  logic [2:0]         scan_cnt;
  logic signed [31:0] run_max;
  logic [1:0]         run_arg;
  logic [1:0]         action;
  logic [5:0]         next_state;
  logic signed [31:0] reward;
  logic [7:0]         eps_cur;

  logic scanning, scan_last, idle_like;
  assign scanning  = (state == S_SCAN_CUR) || (state == S_SCAN_NEXT);
  assign scan_last = (scan_cnt == 3'd4);
  assign idle_like = (state == S_IDLE) || (state == S_DONE);

`ifdef EPS_DECAY_EN
  logic [7:0] eps;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                            eps <= EPS_THRESH;
    else if (idle_like && start)        eps <= EPS_THRESH;
    else if (state == S_EP_END && eps != 8'd0) eps <= eps - 8'd1;
  end
  assign eps_cur = eps;
`else
  assign eps_cur = EPS_THRESH;
`endif

  // Running max including the sample arriving this cycle; first sample seeds it.
  logic signed [31:0] scan_max;
  logic [1:0]         scan_arg;
  always_comb begin
    scan_max = run_max;
    scan_arg = run_arg;
    if (scan_cnt == 3'd1 || bus.q_rd_data > run_max) begin
      scan_max = bus.q_rd_data;
      scan_arg = 2'(scan_cnt - 3'd1);
    end
  end

  // Maze movement: off-grid or blocked target keeps the agent in place.
  logic [5:0]         row, col, tgt, mv_next;
  logic               off, blocked;
  logic signed [31:0] mv_rew;
  always_comb begin
    row = cur_state / 6'd6;
    col = cur_state % 6'd6;
    off = 1'b0;
    tgt = cur_state;
    case (action)
      2'd0: begin off = (row == 6'd0); tgt = cur_state - 6'd6; end
      2'd1: begin off = (col == 6'd5); tgt = cur_state + 6'd1; end
      2'd2: begin off = (row == 6'd5); tgt = cur_state + 6'd6; end
      default: begin off = (col == 6'd0); tgt = cur_state - 6'd1; end
    endcase
    blocked = off || wall_map[tgt];
    mv_next = blocked ? cur_state : tgt;
    if (blocked)                      mv_rew = 32'(REWARD_WALL);
    else if (tgt == 6'(GOAL_STATE))   mv_rew = 32'(REWARD_GOAL);
    else                              mv_rew = '0;
  end

  logic [7:0] step_inc;
  logic       ep_end, explore;
  assign step_inc = step_cnt + 8'd1;
  assign ep_end   = (next_state == 6'(GOAL_STATE)) || (step_inc == 8'(MAX_STEPS));
  assign explore  = (lfsr[7:0] < eps_cur);

  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:      if (start) nxt = S_EP_INIT;
      S_EP_INIT:   nxt = S_SCAN_CUR;
      S_SCAN_CUR:  if (scan_last) nxt = S_CHOOSE;
      S_CHOOSE:    nxt = S_MOVE;
      S_MOVE:      nxt = S_SCAN_NEXT;
      S_SCAN_NEXT: if (scan_last) nxt = S_ISSUE;
      S_ISSUE:     if (bus.upd_ready) nxt = S_ADVANCE;
      S_ADVANCE:   nxt = ep_end ? S_EP_END : S_SCAN_CUR;
      S_EP_END:    nxt = (episode_cnt == 16'(N_EPISODES)) ? S_DONE : S_EP_INIT;
      S_DONE:      if (start) nxt = S_EP_INIT;
      default:     nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy           = !idle_like;
    done           = (state == S_DONE);
    bus.upd_valid  = (state == S_ISSUE);
    bus.q_rd_state = '0;
    bus.q_rd_act   = '0;
    if (scanning && !scan_last) begin
      bus.q_rd_state = (state == S_SCAN_CUR) ? cur_state : next_state;
      bus.q_rd_act   = scan_cnt[1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= S_IDLE;
      lfsr           <= LFSR_SEED;
      scan_cnt       <= '0;
      run_max        <= '0;
      run_arg        <= '0;
      action         <= '0;
      next_state     <= '0;
      reward         <= '0;
      episode_cnt    <= '0;
      step_cnt       <= '0;
      cur_state      <= 6'(START_STATE);
      bus.upd_state  <= '0;
      bus.upd_action <= '0;
      bus.upd_max_q  <= '0;
      bus.upd_reward <= '0;
    end else begin
      state <= nxt;
      lfsr  <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
      case (state)
        S_DONE: if (start) episode_cnt <= '0;
        S_EP_INIT: begin
          cur_state <= 6'(START_STATE);
          step_cnt  <= '0;
        end
        S_SCAN_CUR, S_SCAN_NEXT: begin
          scan_cnt <= scan_last ? 3'd0 : scan_cnt + 3'd1;
          if (scan_cnt != 3'd0) begin
            run_max <= scan_max;
            run_arg <= scan_arg;
          end
          // The request is latched here and held untouched through ISSUE.
          if (state == S_SCAN_NEXT && scan_last) begin
            bus.upd_state  <= cur_state;
            bus.upd_action <= action;
            bus.upd_max_q  <= scan_max;
            bus.upd_reward <= reward;
          end
        end
        S_CHOOSE: action <= explore ? lfsr[9:8] : run_arg;
        S_MOVE: begin
          next_state <= mv_next;
          reward     <= mv_rew;
        end
        S_ADVANCE: begin
          cur_state <= next_state;
          step_cnt  <= step_inc;
          if (ep_end) episode_cnt <= episode_cnt + 16'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_q_episode_ctrl.sv
// Randomized check of q_episode_ctrl against a step-level maze / Q-learning model.
module tb_q_episode_ctrl;
  localparam int N_EP  = 2;
  localparam int MAXS  = 64;
  localparam int START = 0;
  localparam int GOAL  = 35;
  localparam logic [7:0] EPS = 8'd26;
  localparam int LFN   = 100000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [35:0] wall_map = '0;
  logic        busy, done;
  logic [15:0] episode_cnt;
  logic [7:0]  step_cnt;
  logic [5:0]  cur_state;

  q_episode_ctrl_if bus();

  q_episode_ctrl #(
    .N_EPISODES(N_EP), .MAX_STEPS(MAXS), .START_STATE(START), .GOAL_STATE(GOAL),
    .EPS_THRESH(EPS), .REWARD_GOAL(10), .REWARD_WALL(-1), .LFSR_SEED(16'hACE1)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .wall_map(wall_map),
    .busy(busy), .done(done), .episode_cnt(episode_cnt), .step_cnt(step_cnt),
    .cur_state(cur_state), .bus(bus.master)
  );

  always #5 clk = ~clk;

  // Q-table RAM stub with one cycle of read latency
  logic signed [31:0] q_tab [0:35][0:3];
  always @(posedge clk) bus.q_rd_data <= q_tab[bus.q_rd_state][bus.q_rd_act];

  int cyc;
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  logic [15:0] lf [0:LFN-1];

  int n_chk = 0, n_fail = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h @cyc %0d", tag, got, exp, cyc);
    end
  endtask

  // reference model state
  int          m_state, m_step, m_ep, e_issue, e_next;
  logic [7:0]  m_eps;
  logic [1:0]  e_act;
  logic [31:0] e_rew, e_max;

  // Predict one step whose CHOOSE happens in cycle c.
  function automatic void plan(input int c);
    logic [15:0] l;
    int best, r, cl, t;
    bit bump;
    logic signed [31:0] mx;
    l = lf[(c < LFN) ? c : LFN-1];
    best = 0;
    for (int a = 1; a < 4; a++) if (q_tab[m_state][a] > q_tab[m_state][best]) best = a;
    e_act = (l[7:0] < m_eps) ? l[9:8] : 2'(best);
    r = m_state / 6; cl = m_state % 6;
    case (e_act)
      2'd0: begin bump = (r == 0); t = m_state - 6; end
      2'd1: begin bump = (cl == 5); t = m_state + 1; end
      2'd2: begin bump = (r == 5); t = m_state + 6; end
      default: begin bump = (cl == 0); t = m_state - 1; end
    endcase
    if (!bump) bump = wall_map[t];
    e_next = bump ? m_state : t;
    e_rew  = bump ? 32'hFFFF_FFFF : (t == GOAL) ? 32'd10 : 32'd0;
    mx = q_tab[e_next][0];
    for (int a = 1; a < 4; a++) if (q_tab[e_next][a] > mx) mx = q_tab[e_next][a];
    e_max   = mx;
    e_issue = c + 7;
  endfunction

  // pol: 0 ready always high, 1 random ready, 2 ready low for 5 ISSUE cycles
  task automatic run(input int pol, input int budget);
    bit fin = 0;
    int vcnt = 0, done_at = 1 << 30;
    @(negedge clk);
    start = 1'b1;
    m_state = START; m_step = 0; m_ep = 0; m_eps = EPS;
    plan(cyc + 7);
    for (int k = 0; k < budget && !fin; k++) begin
      @(negedge clk);
      start = 1'b0;
      chk("busy", busy, cyc < done_at);
      chk("done", done, cyc >= done_at);
      if (cyc >= done_at) begin
        chk("ep_final", episode_cnt, N_EP);
        fin = 1;
      end else begin
        chk("upd_valid", bus.upd_valid, cyc >= e_issue);
        if (bus.upd_valid) begin
          vcnt++;
          chk("upd_state", bus.upd_state, m_state);
          chk("upd_action", bus.upd_action, e_act);
          chk("upd_max_q", bus.upd_max_q, e_max);
          chk("upd_reward", bus.upd_reward, e_rew);
          chk("step_cnt", step_cnt, m_step);
          chk("cur_state", cur_state, m_state);
          chk("episode_cnt", episode_cnt, m_ep);
        end
        case (pol)
          0:       bus.upd_ready = 1'b1;
          1:       bus.upd_ready = ($urandom_range(0, 3) != 0);
          default: bus.upd_ready = (vcnt >= 6);
        endcase
        if (bus.upd_valid && bus.upd_ready) begin
          e_issue = 1 << 30;
          vcnt = 0;
          m_step++;
          m_state = e_next;
          if (m_state == GOAL || m_step == MAXS) begin
            m_ep++; m_step = 0; m_state = START;
`ifdef EPS_DECAY_EN
            if (m_eps != 8'd0) m_eps--;
`endif
            if (m_ep == N_EP) done_at = cyc + 3;
            else plan(cyc + 9);
          end else plan(cyc + 7);
        end
        if (busy && $urandom_range(0, 31) == 0) start = 1'b1;
      end
    end
    if (!fin) chk("timeout", 0, 1);
  endtask

  task automatic rst_mid();
    int v = 0;
    bit hit = 0;
    @(negedge clk);
    start = 1'b1;
    bus.upd_ready = 1'b1;
    for (int k = 0; k < 400 && !hit; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (bus.upd_valid && step_cnt >= 8'd3) begin
        v++;
        if (v == 2) hit = 1;
      end
      bus.upd_ready = (step_cnt < 8'd3);
    end
    if (!hit) chk("rst_wait", 0, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_upd_valid", bus.upd_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_step", step_cnt, 0);
    chk("rst_ep", episode_cnt, 0);
    chk("rst_cur", cur_state, START);
    chk("rst_upd_state", bus.upd_state, 0);
    rst = 1'b0;
  endtask

  task automatic clear_q();
    for (int s = 0; s < 36; s++) for (int a = 0; a < 4; a++) q_tab[s][a] = '0;
  endtask

  initial begin
    lf[0] = 16'hACE1;
    for (int i = 1; i < LFN; i++) lf[i] = {lf[i-1][0] ^ lf[i-1][2] ^ lf[i-1][3] ^ lf[i-1][5], lf[i-1][15:1]};
    clear_q();
    bus.upd_ready = 1'b1;
    #2 rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rs_busy", busy, 0);
    chk("rs_done", done, 0);
    chk("rs_valid", bus.upd_valid, 0);
    chk("rs_ep", episode_cnt, 0);
    chk("rs_step", step_cnt, 0);
    chk("rs_cur", cur_state, START);
    chk("rs_rd_state", bus.q_rd_state, 0);
    chk("rs_rd_act", bus.q_rd_act, 0);
    chk("rs_max_q", bus.upd_max_q, 0);
    chk("rs_reward", bus.upd_reward, 0);

    // all-zero Q: greedy bumps the top edge
    run(0, 4000);

    // row-0 right / col-5 down corridor to the goal
    clear_q();
    for (int s = 0; s < 5; s++) q_tab[s][1] = 32'sd5 <<< 16;
    for (int r = 0; r < 6; r++) q_tab[r*6+5][2] = 32'sd5 <<< 16;
    run(1, 6000);

    // signed max over mixed values, upd_ready held low for 5 cycles
    for (int s = 0; s < 36; s++) begin
      q_tab[s][0] = -32'sd5 <<< 16; q_tab[s][1] = 32'sd3 <<< 16;
      q_tab[s][2] = 32'sd7 <<< 16;  q_tab[s][3] = -32'sd2 <<< 16;
    end
    run(2, 7000);

    // all equal negative: argmax 0
    for (int s = 0; s < 36; s++) for (int a = 0; a < 4; a++) q_tab[s][a] = -32'sd3 <<< 16;
    run(0, 4000);

    // wall right of the start cell
    clear_q();
    for (int s = 0; s < 36; s++) q_tab[s][1] = 32'sd1 <<< 16;
    wall_map = 36'h2;
    run(1, 6000);

    clear_q();
    wall_map = '0;
    rst_mid();
    run(0, 4000);

    repeat (3) begin
      for (int s = 0; s < 36; s++) for (int a = 0; a < 4; a++)
        q_tab[s][a] = 32'(int'($urandom_range(0, 6)) - 3) <<< 16;
      wall_map = '0;
      for (int i = 1; i < 35; i++) wall_map[i] = ($urandom_range(0, 99) < 15);
      run(1, 6000);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
